// File: rtl/ul8_alu_pkg.sv
// Shared types and constants for the UL8 execute-stage ALU.
// Build option: ALU_FLAGS_EN adds registered carry/zero/negative flags.
package ul8_alu_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_NAND = 2'b01,
        ALU_NOT  = 2'b10,
        ALU_AND  = 2'b11
    } alu_op_e;

    // Packed so it maps directly onto a 3-bit flag bus {c, zf, nf}.
    typedef struct packed {
        logic c;
        logic zf;
        logic nf;
    } alu_flags_t;

endpackage

// File: rtl/ul8_alu_comb.sv
// Combinational datapath of the UL8 ALU: result and next-flags from x, y and op.
// Build option: ALU_FLAGS_EN adds the flags output.
module ul8_alu_comb
    import ul8_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] z
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    alu_op_e          op_sel;
    logic [WIDTH-1:0] sum;

    assign op_sel = alu_op_e'(op);

`ifdef ALU_FLAGS_EN
    logic carry;
    assign {carry, sum} = {1'b0, x} + {1'b0, y};
`else
    assign sum = x + y;
`endif

    always_comb begin
        z = '0;
        unique case (op_sel)
            ALU_ADD:  z = sum;
            ALU_NAND: z = ~(x & y);
            ALU_NOT:  z = ~x;
            ALU_AND:  z = x & y;
        endcase
    end

`ifdef ALU_FLAGS_EN
    alu_flags_t flags_next;

    always_comb begin
        flags_next    = '0;
        // Only ADD can produce a carry; logic ops always clear it.
        flags_next.c  = (op_sel == ALU_ADD) ? carry : 1'b0;
        flags_next.zf = (z == '0);
        flags_next.nf = z[WIDTH-1];
    end

    assign flags = flags_next;
`endif

endmodule

// File: rtl/ul8_alu.sv
// UL8 ALU top: enable/reset output registers around the combinational datapath.
// Build option: ALU_FLAGS_EN adds c_out, zf_out and nf_out, registered with z_out.
module ul8_alu
    import ul8_alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [1:0]       op_in,
    output logic [WIDTH-1:0] z_out
`ifdef ALU_FLAGS_EN
    ,
    output logic             c_out,
    output logic             zf_out,
    output logic             nf_out
`endif
);

    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;

`ifdef ALU_FLAGS_EN
    logic [2:0] flags_d;
    alu_flags_t flags_q;
`endif

    ul8_alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .x     (x_in),
        .y     (y_in),
        .op    (op_in),
        .z     (z_d)
`ifdef ALU_FLAGS_EN
        ,
        .flags (flags_d)
`endif
    );

    // Reset wins over enable, even when a result would otherwise load.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q <= '0;
        end else if (en_in) begin
            z_q <= z_d;
        end
    end

    assign z_out = z_q;

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (en_in) begin
            flags_q <= alu_flags_t'(flags_d);
        end
    end

    assign c_out  = flags_q.c;
    assign zf_out = flags_q.zf;
    assign nf_out = flags_q.nf;
`endif

endmodule

// File: tb/tb_ul8_alu.sv
// Self-checking bench for ul8_alu; flag checks compile in when ALU_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_ul8_alu;

    typedef struct {
        logic [7:0] z;
        logic       c;
        logic       zf;
        logic       nf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en_in;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [1:0] op_in;
    logic [7:0] z_out;
`ifdef ALU_FLAGS_EN
    logic       c_out;
    logic       zf_out;
    logic       nf_out;
`endif

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    ul8_alu dut (
        .clk    (clk),
        .rst    (rst),
        .en_in  (en_in),
        .x_in   (x_in),
        .y_in   (y_in),
        .op_in  (op_in),
        .z_out  (z_out)
`ifdef ALU_FLAGS_EN
        ,
        .c_out  (c_out),
        .zf_out (zf_out),
        .nf_out (nf_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for randomised traffic.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic [1:0] op);
        exp_t       e;
        logic [8:0] s;
        s   = {1'b0, x} + {1'b0, y};
        e.c = 1'b0;
        case (op)
            2'b00: begin e.z = s[7:0]; e.c = s[8]; end
            2'b01: e.z = ~(x & y);
            2'b10: e.z = ~x;
            default: e.z = x & y;
        endcase
        e.zf = (e.z == 8'h00);
        e.nf = e.z[7];
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] z, input logic c, input logic zf,
                                input logic nf);
        exp_t e;
        e.z = z; e.c = c; e.zf = zf; e.nf = nf;
        return e;
    endfunction

    task automatic drive(input logic r, input logic en, input logic [7:0] x,
                         input logic [7:0] y, input logic [1:0] op);
        rst = r; en_in = en; x_in = x; y_in = y; op_in = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        step();
        step();
        e = exp_q.pop_front();
        checks++;
        if (z_out !== e.z) begin
            errors++;
            $display("FAIL reset z: got %h expected %h", z_out, e.z);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if ({c_out, zf_out, nf_out} !== {e.c, e.zf, e.nf}) begin
            errors++;
            $display("FAIL reset flags: got %b expected %b", {c_out, zf_out, nf_out},
                     {e.c, e.zf, e.nf});
        end
`endif
    endtask

    task automatic test_ops();
        logic [7:0] xs[6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'hFF, 8'h7F};
        logic [7:0] ys[6] = '{8'h0D, 8'h0D, 8'h0D, 8'h0D, 8'h01, 8'h01};
        logic [1:0] ops[6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        exp_t exps[6];
        exp_t e;
        exps[0] = mk(8'h2D, 1'b0, 1'b0, 1'b0);
        exps[1] = mk(8'hFF, 1'b0, 1'b0, 1'b1);
        exps[2] = mk(8'hDF, 1'b0, 1'b0, 1'b1);
        exps[3] = mk(8'h00, 1'b0, 1'b1, 1'b0);
        exps[4] = mk(8'h00, 1'b1, 1'b1, 1'b0);
        exps[5] = mk(8'h80, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, xs[i], ys[i], ops[i]);
            exp_q.push_back(exps[i]);
            step();
            e = exp_q.pop_front();
            checks++;
            if (z_out !== e.z) begin
                errors++;
                $display("FAIL ops[%0d] z: got %h expected %h", i, z_out, e.z);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({c_out, zf_out, nf_out} !== {e.c, e.zf, e.nf}) begin
                errors++;
                $display("FAIL ops[%0d] flags: got %b expected %b", i,
                         {c_out, zf_out, nf_out}, {e.c, e.zf, e.nf});
            end
`endif
        end
    endtask

    task automatic test_hold();
        exp_t e;
        drive(1'b0, 1'b1, 8'h20, 8'h0D, 2'b00);
        exp_q.push_back(mk(8'h2D, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(8'h2D, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step();
            // Disabled cycles present operands that would change every output.
            drive(1'b0, 1'b0, 8'hFF, 8'h01, 2'(i));
            e = exp_q.pop_front();
            checks++;
            if (z_out !== e.z) begin
                errors++;
                $display("FAIL hold[%0d] z: got %h expected %h", i, z_out, e.z);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({c_out, zf_out, nf_out} !== {e.c, e.zf, e.nf}) begin
                errors++;
                $display("FAIL hold[%0d] flags: got %b expected %b", i,
                         {c_out, zf_out, nf_out}, {e.c, e.zf, e.nf});
            end
`endif
        end
    endtask

    task automatic test_reset_priority();
        exp_t e;
        // Start from a non-zero result so the reset is observable.
        drive(1'b0, 1'b1, 8'h20, 8'h0D, 2'b01);
        step();
        drive(1'b1, 1'b1, 8'h20, 8'h0D, 2'b00);
        exp_q.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0));
        step();
        drive(1'b0, 1'b1, 8'h20, 8'h0D, 2'b00);
        exp_q.push_back(mk(8'h2D, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            if (i == 1) step();
            e = exp_q.pop_front();
            checks++;
            if (z_out !== e.z) begin
                errors++;
                $display("FAIL rst_prio[%0d] z: got %h expected %h", i, z_out, e.z);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({c_out, zf_out, nf_out} !== {e.c, e.zf, e.nf}) begin
                errors++;
                $display("FAIL rst_prio[%0d] flags: got %b expected %b", i,
                         {c_out, zf_out, nf_out}, {e.c, e.zf, e.nf});
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] op;
        for (int i = 0; i < 24; i++) begin
            x  = 8'($urandom);
            y  = 8'($urandom);
            op = 2'(i);
            drive(1'b0, 1'b1, x, y, op);
            exp_q.push_back(model(x, y, op));
            step();
            e = exp_q.pop_front();
            checks++;
            if (z_out !== e.z) begin
                errors++;
                $display("FAIL b2b[%0d] z: got %h expected %h (x=%h y=%h op=%0d)", i, z_out,
                         e.z, x, y, op);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({c_out, zf_out, nf_out} !== {e.c, e.zf, e.nf}) begin
                errors++;
                $display("FAIL b2b[%0d] flags: got %b expected %b", i,
                         {c_out, zf_out, nf_out}, {e.c, e.zf, e.nf});
            end
`endif
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
        test_reset();
        test_ops();
        test_hold();
        test_reset_priority();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
